rv32_multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the team's single-cycle RV32 datapath.
- Executes an RV32I subset over an FSM: one shared ALU, and one unified instruction/data memory port with a ready handshake.
- Sits as the CPU top, with an external memory model or bus bridge on its memory port.
- Supports an optional RV32E register-file size and variable-latency memory; illegal or misaligned operations halt the core.

---
 rtl/rv32_multicycle_core_if.sv | 14 +
 rtl/rv32_multicycle_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_rv32_multicycle_core.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_multicycle_core_if.sv
// Unified instruction/data memory port with a request/ready handshake.
interface rv32_multicycle_core_if #(
    parameter int unsigned MEM_AW = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I-subset core: shared ALU, one memory port, halts on illegal/misaligned ops.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned MEM_AW    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    rv32_multicycle_core_if.master        mem,
    output logic                          retire,
    output logic                          halt,
    output logic [31:0]                   pc_dbg
);
    localparam int unsigned RIW = (REG_COUNT == 16) ? 4 : 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]       imm_q, imm_d, tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              retire_q, retire_d, halt_q, halt_d;
    logic [31:0]       rf_q [REG_COUNT];

    logic              rf_we;
    logic [RIW-1:0]    rf_waddr;
    logic [31:0]       rf_wdata;
    logic [31:0]       alu_a, alu_b, alu_y;
    alu_op_t           alu_op, exec_op;
    logic              xfer, go_fetch;
    logic [31:0]       next_pc, pc_plus4;

    logic [6:0]        opcode, f7;
    logic [2:0]        f3;
    logic [RIW-1:0]    rs1_idx, rs2_idx, rd_idx;
    logic [31:0]       imm_i, imm_s, imm_b, imm_j, imm_sel;
    logic              legal, use_rs1, use_rs2, use_rd;
    state_t            dec_state;

    assign opcode   = ir_q[6:0];
    assign f3       = ir_q[14:12];
    assign f7       = ir_q[31:25];
    assign rs1_idx  = ir_q[15 +: RIW];
    assign rs2_idx  = ir_q[20 +: RIW];
    assign rd_idx   = ir_q[7 +: RIW];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign xfer     = mem_req_q & mem.mem_ready;
    assign pc_plus4 = pc_q + 32'd4;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign retire        = retire_q;
    assign halt          = halt_q;
    assign pc_dbg        = pc_q;

    // Instruction legality, operand usage and post-decode state
    always_comb begin
        legal     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        dec_state = S_HALT;
        imm_sel   = imm_i;
        case (opcode)
            OP_LOAD:   begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rd = 1'b1; dec_state = S_MEMADR; end
            OP_STORE:  begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1;
                             dec_state = S_MEMADR; imm_sel = imm_s; end
            OP_OP:     begin
                legal = ((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                        ((f7 == 7'b0100000) && (f3 == 3'b000));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; dec_state = S_EXECR;
            end
            OP_IMM:    begin legal = (f3 inside {3'b000, 3'b111, 3'b110, 3'b010});
                             use_rs1 = 1'b1; use_rd = 1'b1; dec_state = S_EXECI; end
            OP_BRANCH: begin legal = (f3 == 3'b000); use_rs1 = 1'b1; use_rs2 = 1'b1;
                             dec_state = S_BEQ; imm_sel = imm_b; end
            OP_JAL:    begin legal = 1'b1; use_rd = 1'b1; dec_state = S_JAL; imm_sel = imm_j; end
            default:   legal = 1'b0;
        endcase
        // RV32E: upper 16 register indices do not exist
        if ((REG_COUNT == 16) && ((use_rs1 && ir_q[19]) || (use_rs2 && ir_q[24]) || (use_rd && ir_q[11])))
            legal = 1'b0;
        case (f3)
            3'b111:  exec_op = ALU_AND;
            3'b110:  exec_op = ALU_OR;
            3'b010:  exec_op = ALU_SLT;
            default: exec_op = ((opcode == OP_OP) && f7[5]) ? ALU_SUB : ALU_ADD;
        endcase
    end

    // Shared ALU
    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = 32'(($signed(alu_a) < $signed(alu_b)) ? 1 : 0);
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        tgt_d       = tgt_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        retire_d    = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = rd_idx;
        rf_wdata    = alu_q;
        alu_a       = a_q;
        alu_b       = imm_q;
        alu_op      = ALU_ADD;
        go_fetch    = 1'b0;
        next_pc     = pc_plus4;
        case (state_q)
            S_FETCH: begin
                mem_req_d  = 1'b1;
                mem_addr_d = MEM_AW'(pc_q);
                if (xfer) begin
                    ir_d      = mem.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs1_idx];
                b_d     = rf_q[rs2_idx];
                imm_d   = imm_sel;
                alu_a   = pc_q;
                alu_b   = imm_sel;
                tgt_d   = alu_y;
                state_d = legal ? dec_state : S_HALT;
            end
            S_MEMADR: begin
                alu_d = alu_y;
                if (alu_y[1:0] != 2'b00) begin
                    state_d = S_HALT;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = MEM_AW'(alu_y);
                    if (opcode == OP_STORE) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = b_q;
                        state_d     = S_MEMWRITE;
                    end else begin
                        state_d = S_MEMREAD;
                    end
                end
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                if (xfer) begin
                    mdr_d     = mem.mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                go_fetch = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                go_fetch  = xfer;
            end
            S_EXECR, S_EXECI: begin
                alu_b   = (state_q == S_EXECR) ? b_q : imm_q;
                alu_op  = exec_op;
                alu_d   = alu_y;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                go_fetch = 1'b1;
            end
            S_BEQ: begin
                if ((a_q == b_q) && (tgt_q[1:0] != 2'b00)) begin
                    state_d = S_HALT;
                end else begin
                    next_pc  = (a_q == b_q) ? tgt_q : pc_plus4;
                    go_fetch = 1'b1;
                end
            end
            S_JAL: begin
                if (tgt_q[1:0] != 2'b00) begin
                    state_d = S_HALT;
                end else begin
                    rf_we    = 1'b1;
                    rf_wdata = pc_plus4;
                    next_pc  = tgt_q;
                    go_fetch = 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase
        // Retire the instruction and launch the next fetch in the same edge
        if (go_fetch) begin
            pc_d       = next_pc;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = MEM_AW'(next_pc);
        end
        halt_d = (state_d == S_HALT);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            tgt_q       <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            tgt_q       <= tgt_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            halt_q      <= halt_d;
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_q <= '{default: '0};
        end else if (rf_we && (rf_waddr != '0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench: ALU/memory/branch program, fault halts, async reset abort, RV32E index check.
module tb_rv32_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        retire, halt, retire2, halt2;
    logic [31:0] pc_dbg, pc_dbg2;
    logic [31:0] mem [256];
    logic [7:0]  mword;
    int          wcnt;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          rt_q[$];
    logic [31:0] rpc_q[$];
    int          both_cnt = 0, st_cyc = 0, st_bad = 0, r2_cnt = 0;
    int          cyc_rel;
    logic [31:0] exp_pc [14];

    rv32_multicycle_core_if #(.MEM_AW(32)) m ();
    rv32_multicycle_core_if #(.MEM_AW(32)) m2 ();

    rv32_multicycle_core #(.RESET_PC(32'h100), .REG_COUNT(32), .MEM_AW(32)) dut (
        .clk(clk), .rst(rst), .mem(m.master), .retire(retire), .halt(halt), .pc_dbg(pc_dbg));

    rv32_multicycle_core #(.RESET_PC(32'h0), .REG_COUNT(16), .MEM_AW(32)) dut_e (
        .clk(clk), .rst(rst), .mem(m2.master), .retire(retire2), .halt(halt2), .pc_dbg(pc_dbg2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word 2 (address 8) answers after 2 wait cycles, or never while hold=1
    assign mword       = m.mem_addr[9:2];
    assign m.mem_rdata = mem[mword];
    assign m.mem_ready = m.mem_req && !(hold && mword == 8'd2) && (wcnt >= ((mword == 8'd2) ? 2 : 0));
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 0;
        end else begin
            wcnt <= (m.mem_req && !m.mem_ready) ? wcnt + 1 : 0;
            if (m.mem_req && m.mem_we && m.mem_ready) mem[mword] = m.mem_wdata;
        end
    end

    // RV32E instance always fetches addi x20,x0,1
    assign m2.mem_rdata = 32'h00100A13;
    assign m2.mem_ready = m2.mem_req;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (retire) begin rt_q.push_back(cyc); rpc_q.push_back(pc_dbg); end
            if (retire && halt) both_cnt++;
            if (retire2) r2_cnt++;
            if (m.mem_req && m.mem_we && m.mem_addr == 32'd8) begin
                st_cyc++;
                if (m.mem_wdata !== 32'd8) st_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_retires(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && rt_q.size() < n; i++) @(negedge clk);
        check(tag, 32'(rt_q.size()), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'h00500093;  // addi x1,x0,5
        mem[65] = 32'hFFD00113;  // addi x2,x0,-3
        mem[66] = 32'h402081B3;  // sub  x3,x1,x2
        mem[67] = 32'h00112233;  // slt  x4,x2,x1
        mem[68] = 32'h08402023;  // sw   x4,0x80(x0)
        mem[69] = 32'hEFDFF06F;  // jal  x0,0x10
        mem[4]  = 32'h00108463;  // 0x10: beq x1,x1,+8
        mem[5]  = 32'h02C0006F;  // 0x14: jal x0,0x40
        mem[6]  = 32'hFFDFF36F;  // 0x18: jal x6,-4
        mem[16] = 32'h08602223;  // 0x40: sw x6,0x84(x0)
        mem[17] = 32'h00302423;  // 0x44: sw x3,8(x0)
        mem[18] = 32'h00802283;  // 0x48: lw x5,8(x0)
        mem[19] = 32'h08502423;  // 0x4C: sw x5,0x88(x0)
        mem[20] = 32'h08002623;  // 0x50: sw x0,0x8C(x0)
        mem[21] = 32'h00602383;  // 0x54: lw x7,6(x0)
        mem[35] = 32'hDEADBEEF;
        exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h10, 32'h18,
                   32'h14, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54};

        // Reset state and first fetch
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(m.mem_req), 32'd0);
        check("rst_mem_we", 32'(m.mem_we), 32'd0);
        check("rst_mem_addr", m.mem_addr, 32'd0);
        check("rst_mem_wdata", m.mem_wdata, 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_pc", pc_dbg, 32'h100);
        rst = 1'b1;
        cyc_rel = cyc;
        @(negedge clk);
        check("fetch_req", 32'(m.mem_req), 32'd1);
        check("fetch_addr", m.mem_addr, 32'h100);
        check("fetch_halt", 32'(halt), 32'd0);

        // Main program
        wait_retires(14, 300, "prog_retires");
        if (rt_q.size() >= 14) begin
            check("alu_total_cycles", 32'(rt_q[3] - (cyc_rel + 1)), 32'd16);
            for (int i = 1; i < 4; i++) check("alu_latency", 32'(rt_q[i] - rt_q[i-1]), 32'd4);
            check("beq_latency", 32'(rt_q[6] - rt_q[5]), 32'd3);
            check("jal_latency", 32'(rt_q[7] - rt_q[6]), 32'd3);
            check("sw_wait_latency", 32'(rt_q[10] - rt_q[9]), 32'd6);
            check("lw_wait_latency", 32'(rt_q[11] - rt_q[10]), 32'd7);
            for (int i = 0; i < 14; i++) check("retire_pc", rpc_q[i], exp_pc[i]);
        end
        for (int i = 0; i < 50 && !halt; i++) @(negedge clk);
        check("misaligned_lw_halt", 32'(halt), 32'd1);
        check("misaligned_lw_no_retire", 32'(rt_q.size()), 32'd14);
        check("halt_pc", pc_dbg, 32'h54);
        check("halt_mem_req", 32'(m.mem_req), 32'd0);
        check("x4_slt", mem[32], 32'd1);
        check("x6_link", mem[33], 32'h1C);
        check("x3_sub", mem[2], 32'd8);
        check("x5_load", mem[34], 32'd8);
        check("x0_zero", mem[35], 32'd0);
        check("sw_wait_cycles", 32'(st_cyc), 32'd3);
        check("sw_wdata_stable", 32'(st_bad), 32'd0);
        check("retire_with_halt", 32'(both_cnt), 32'd0);

        // Illegal opcode
        rst = 1'b0;
        mem[64] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rt_q.delete(); rpc_q.delete();
        @(negedge clk);
        check("illegal_fetch_req", 32'(m.mem_req), 32'd1);
        @(negedge clk);
        check("illegal_decode_halt", 32'(halt), 32'd0);
        @(negedge clk);
        check("illegal_halt", 32'(halt), 32'd1);
        repeat (3) @(negedge clk);
        check("illegal_req_low", 32'(m.mem_req), 32'd0);
        check("illegal_pc", pc_dbg, 32'h100);
        check("illegal_no_retire", 32'(rt_q.size()), 32'd0);

        // Async reset during a stalled load
        rst = 1'b0;
        mem[64] = 32'h00802283;  // lw x5,8(x0)
        hold = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30 && !(m.mem_req && !m.mem_we && m.mem_addr == 32'd8); i++) @(negedge clk);
        check("lw_stall_seen", 32'(m.mem_req && !m.mem_we && m.mem_addr == 32'd8), 32'd1);
        repeat (2) @(negedge clk);
        check("lw_still_stalled", 32'(m.mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_req_async", 32'(m.mem_req), 32'd0);
        check("abort_pc", pc_dbg, 32'h100);
        mem[64] = 32'h08502423;  // sw x5,0x88(x0)
        mem[34] = 32'hDEADBEEF;
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rt_q.delete(); rpc_q.delete();
        @(negedge clk);
        check("restart_addr", m.mem_addr, 32'h100);
        wait_retires(1, 30, "restart_retire");
        check("abort_no_rd_write", mem[34], 32'd0);

        // RV32E instance: addi x20 is out of range
        check("rv32e_halt", 32'(halt2), 32'd1);
        check("rv32e_no_retire", 32'(r2_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
